compare_stream: RTL and testbench
=================================

Name: compare_stream

Overview:
Parametrised, pipelined, streaming magnitude/equality comparator. It is the successor to the 8-bit combinational equality compare block.
- Adds: generic width, signed/unsigned arithmetic, run-time selectable compare mode and a valid handshake.
- Adds statistics: a saturating match counter and a consecutive-match (run) detector.
- Sits on a sample stream feeding threshold/pattern-detect logic downstream.

Parameters:
WIDTH, 8, operand width in bits (>=1)
SIGNED, 0, 1 = operands are two's complement, 0 = unsigned
CNT_W, 16, width of match counter (>=2)
RUN_LEN, 4, consecutive matches required for run_hit (>=1, <=2^16-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  a/b/mode valid this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
mode  input  3  compare mode, sampled with in_valid
clear  input  1  synchronous clear of statistics only
out_valid  output  1  result outputs valid this cycle
result  output  1  selected comparison outcome
equal  output  1  a == b
less  output  1  a < b (per SIGNED)
greater  output  1  a > b (per SIGNED)
match_cnt  output  CNT_W  number of valid samples with result=1 since rst/clear
cnt_sat  output  1  sticky: match_cnt reached all-ones
run_hit  output  1  current run of consecutive matches >= RUN_LEN

Behaviour:
- Reset (rst=1 at edge): out_valid, result, equal, less, greater, run_hit, cnt_sat = 0; match_cnt = 0.
  - Internal run counter and both pipeline valid bits = 0.
  - Reset mid-stream discards any in-flight samples; no out_valid follows.
- Pipeline: 2 stages, fixed latency 2.
  - Stage 1 registers a, b, mode and in_valid when in_valid=1; the stage-1 valid bit follows in_valid every cycle.
  - Stage 2 computes flags from the stage-1 registers and registers all outputs.
  - A sample presented at edge N appears with out_valid=1 after edge N+2.
  - Full throughput: back-to-back samples are accepted every cycle; no backpressure.
- Flags: exactly one of equal/less/greater = 1 when out_valid=1.
  - SIGNED=1 compares as two's complement; SIGNED=0 as unsigned.
- Mode codes:
  - 0 EQ; 1 NE; 2 LT; 3 GT; 4 LE; 5 GE.
  - 6 and 7 reserved: result = 0, flags still valid.
- Idle cycles (out_valid=0): result, equal, less, greater and run_hit are driven 0.
  - match_cnt and cnt_sat hold their values.
- Statistics update on the same edge that registers a valid stage-2 output, so the out_valid cycle already reflects that sample.
- match_cnt:
  - +1 per valid sample with result=1.
  - Saturates at 2^CNT_W-1, with no wrap.
  - cnt_sat is set on the edge the count becomes all-ones and stays set until rst or clear.
- Run counter (internal, 16-bit):
  - A valid result=1 increments it, saturating at RUN_LEN.
  - A valid result=0 zeroes it.
  - Bubbles (in_valid=0 gaps) neither break nor advance a run.
- run_hit: asserted in an out_valid cycle whose sample brings the run counter to >= RUN_LEN.
  - Stays asserted for each further consecutive match.
- clear:
  - Zeroes match_cnt, cnt_sat and the run counter.
  - Does not affect the pipeline, out_valid or the flags.
  - If clear coincides with a counting sample, clear wins: the sample is not counted and run_hit = 0 that cycle, while result/flags still appear.
- rst has priority over clear and over in_valid.

Test Plan:
- WIDTH=8, mode=EQ; samples (0,0), (100,99), (100,100), (99,100) back-to-back.
  - out_valid for 4 cycles starting 2 edges after the first sample.
  - result = 1,0,1,0; greater=1 for (100,99); less=1 for (99,100); match_cnt ends at 2.
- WIDTH=8, a=8'hFF, b=8'h01, mode=LT.
  - SIGNED=1 -> result=1, less=1.
  - SIGNED=0 -> result=0, greater=1.
- RUN_LEN=4, mode=EQ; 5 equal samples with 2 bubble cycles between the 2nd and 3rd, then 1 unequal sample.
  - run_hit=1 on the 4th and 5th outputs only; 0 on the 6th.
  - match_cnt=5.
- CNT_W=3, mode=GE; 9 matching samples.
  - match_cnt reaches 7 on the 7th output and holds 7; cnt_sat=1 from the 7th output on.
  - clear -> match_cnt=0, cnt_sat=0.
- clear asserted on the edge registering a matching output.
  - result=1 and out_valid=1 that cycle; match_cnt=0 and run_hit=0 after.
- rst asserted for 1 cycle while 2 samples are in flight.
  - No out_valid for those samples; all outputs 0.
  - The next sample produces out_valid exactly 2 edges after it is applied.

Source files
------------

// File: rtl/compare_stream.sv
// compare_stream: pipelined equality/magnitude comparator with match statistics.
// Latency: 2 cycles from an accepted sample to its out_valid result.
// Backpressure: none; one sample per cycle is always accepted and never stalled.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid, a, b, mode      input sample; mode selects EQ/NE/LT/GT/LE/GE (6,7 reserved)
//   clear                     zeroes the statistics only (match_cnt, cnt_sat, run counter)
//   out_valid, result         registered result of the selected compare
//   equal, less, greater      one-hot relation flags, valid with out_valid
//   match_cnt, cnt_sat        saturating count of result=1 samples, sticky saturation flag
//   run_hit                   current consecutive-match run has reached RUN_LEN
module compare_stream #(
    parameter int WIDTH   = 8,
    parameter int SIGNED  = 0,
    parameter int CNT_W   = 16,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    output logic             result,
    output logic             equal,
    output logic             less,
    output logic             greater,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             run_hit
);

    localparam logic [2:0] MODE_EQ = 3'd0;
    localparam logic [2:0] MODE_NE = 3'd1;
    localparam logic [2:0] MODE_LT = 3'd2;
    localparam logic [2:0] MODE_GT = 3'd3;
    localparam logic [2:0] MODE_LE = 3'd4;
    localparam logic [2:0] MODE_GE = 3'd5;

    // The run counter never needs to go beyond RUN_LEN, so it saturates there.
    localparam logic [15:0] RUN_MAX = 16'(RUN_LEN);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       mode;
    } smp_t;

    // ---------------- stage 1: capture the sample ----------------
    smp_t s1_dat;
    logic s1_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat.a    <= a;
                s1_dat.b    <= b;
                s1_dat.mode <= mode;
            end
        end
    end

    // ---------------- stage 2: compare on the captured sample ----------------
    logic cmp_eq;
    logic cmp_lt;
    logic cmp_gt;
    logic cmp_res;

    always_comb begin
        cmp_eq = (s1_dat.a == s1_dat.b);
        if (SIGNED != 0) begin
            cmp_lt = ($signed(s1_dat.a) < $signed(s1_dat.b));
        end else begin
            cmp_lt = (s1_dat.a < s1_dat.b);
        end
        // Derived so that exactly one flag is ever set.
        cmp_gt = !cmp_eq && !cmp_lt;

        case (s1_dat.mode)
            MODE_EQ: cmp_res = cmp_eq;
            MODE_NE: cmp_res = !cmp_eq;
            MODE_LT: cmp_res = cmp_lt;
            MODE_GT: cmp_res = cmp_gt;
            MODE_LE: cmp_res = cmp_lt || cmp_eq;
            MODE_GE: cmp_res = cmp_gt || cmp_eq;
            default: cmp_res = 1'b0;
        endcase
    end

    // ---------------- statistics next-state ----------------
    logic [15:0]      run_cnt;
    logic [15:0]      run_inc;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    assign run_inc = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= 1'b0;
            equal     <= 1'b0;
            less      <= 1'b0;
            greater   <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            run_cnt   <= '0;
            run_hit   <= 1'b0;
        end else begin
            // Result and flags are gated so idle cycles present all zeros.
            out_valid <= s1_vld;
            result    <= s1_vld & cmp_res;
            equal     <= s1_vld & cmp_eq;
            less      <= s1_vld & cmp_lt;
            greater   <= s1_vld & cmp_gt;

            // Statistics reflect the sample in the same cycle it is output;
            // clear takes precedence over a counting sample.
            if (clear) begin
                match_cnt <= '0;
                cnt_sat   <= 1'b0;
                run_cnt   <= '0;
                run_hit   <= 1'b0;
            end else if (s1_vld && cmp_res) begin
                match_cnt <= cnt_inc;
                cnt_sat   <= cnt_sat | (&cnt_inc);
                run_cnt   <= run_inc;
                run_hit   <= (run_inc >= RUN_MAX);
            end else if (s1_vld) begin
                run_cnt   <= '0;
                run_hit   <= 1'b0;
            end else begin
                // Bubble: the run is held, but run_hit is only shown with a valid output.
                run_hit   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_compare_stream.sv
// tb_compare_stream: directed scenarios plus randomized traffic against a reference model.
// Three DUT instances share the stimulus: unsigned, signed, and a 3-bit counter variant.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.
module tb_compare_stream;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a        = 8'd0;
    logic [7:0] b        = 8'd0;
    logic [2:0] mode     = 3'd0;
    logic       clear    = 1'b0;

    logic [2:0]  ov, rs, eq, lt, gt, hit, sat;
    logic [15:0] cnt0, cnt1;
    logic [2:0]  cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    int         sgn  [3] = '{0, 1, 0};
    int         cmax [3] = '{65535, 65535, 7};
    int         m_cnt[3] = '{0, 0, 0};
    int         m_run[3] = '{0, 0, 0};
    logic [2:0] m_sat = 3'b0;
    logic [2:0] e_ov = 3'b0, e_rs = 3'b0, e_eq = 3'b0, e_lt = 3'b0, e_gt = 3'b0, e_hit = 3'b0;
    // Sample driven in the previous cycle (the one whose result appears next).
    logic       p_v = 1'b0;
    logic [7:0] p_a = 8'd0, p_b = 8'd0;
    logic [2:0] p_m = 3'd0;

    always #5 clk = ~clk;

    compare_stream #(.WIDTH(8), .SIGNED(0), .CNT_W(16), .RUN_LEN(4)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .clear(clear),
        .out_valid(ov[0]), .result(rs[0]), .equal(eq[0]), .less(lt[0]), .greater(gt[0]),
        .match_cnt(cnt0), .cnt_sat(sat[0]), .run_hit(hit[0]));

    compare_stream #(.WIDTH(8), .SIGNED(1), .CNT_W(16), .RUN_LEN(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .clear(clear),
        .out_valid(ov[1]), .result(rs[1]), .equal(eq[1]), .less(lt[1]), .greater(gt[1]),
        .match_cnt(cnt1), .cnt_sat(sat[1]), .run_hit(hit[1]));

    compare_stream #(.WIDTH(8), .SIGNED(0), .CNT_W(3), .RUN_LEN(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .clear(clear),
        .out_valid(ov[2]), .result(rs[2]), .equal(eq[2]), .less(lt[2]), .greater(gt[2]),
        .match_cnt(cnt2), .cnt_sat(sat[2]), .run_hit(hit[2]));

    // Expected outputs after the coming edge, computed from the compare rules on integers.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int av;
            int bv;
            bit r;
            if (rst) begin
                e_ov[i] = 0; e_rs[i] = 0; e_eq[i] = 0; e_lt[i] = 0; e_gt[i] = 0; e_hit[i] = 0;
                m_cnt[i] = 0; m_sat[i] = 0; m_run[i] = 0;
            end else begin
                av = (sgn[i] != 0) ? int'($signed(p_a)) : int'(p_a);
                bv = (sgn[i] != 0) ? int'($signed(p_b)) : int'(p_b);
                case (p_m)
                    3'd0:    r = (av == bv);
                    3'd1:    r = (av != bv);
                    3'd2:    r = (av <  bv);
                    3'd3:    r = (av >  bv);
                    3'd4:    r = (av <= bv);
                    3'd5:    r = (av >= bv);
                    default: r = 0;
                endcase
                e_ov[i] = p_v;
                e_rs[i] = p_v && r;
                e_eq[i] = p_v && (av == bv);
                e_lt[i] = p_v && (av <  bv);
                e_gt[i] = p_v && (av >  bv);
                if (clear) begin
                    m_cnt[i] = 0; m_sat[i] = 0; m_run[i] = 0; e_hit[i] = 0;
                end else if (p_v && r) begin
                    if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == cmax[i]) m_sat[i] = 1;
                    if (m_run[i] < 4) m_run[i] = m_run[i] + 1;
                    e_hit[i] = (m_run[i] >= 4);
                end else if (p_v) begin
                    m_run[i] = 0; e_hit[i] = 0;
                end else begin
                    e_hit[i] = 0;
                end
            end
        end
        p_v = in_valid && !rst;
        p_a = a;
        p_b = b;
        p_m = mode;
    endtask

    task automatic tick(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [2:0] m, input logic clr, input logic r);
        in_valid = v; a = aa; b = bb; mode = m; clear = clr; rst = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1);
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], rs[i], eq[i], lt[i], gt[i], hit[i], sat[i]} !== 7'b0) begin
                errors++;
                $display("FAIL reset_flags inst%0d: got %b expected 0000000", i,
                         {ov[i], rs[i], eq[i], lt[i], gt[i], hit[i], sat[i]});
            end
        end
        checks++;
        if (cnt0 !== 16'd0 || cnt2 !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt2);
        end
        idle(2);
    endtask

    task automatic test_eq_sequence();
        logic [7:0] ta[4] = '{8'd0, 8'd100, 8'd100, 8'd99};
        logic [7:0] tb[4] = '{8'd0, 8'd99, 8'd100, 8'd100};
        logic [5:0] g_ov, g_rs, g_gt, g_lt, g_eq;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) tick(1'b1, ta[k], tb[k], 3'd0, 1'b0, 1'b0);
            else       tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
            g_ov[k] = ov[0]; g_rs[k] = rs[0]; g_gt[k] = gt[0]; g_lt[k] = lt[0]; g_eq[k] = eq[0];
        end
        checks++;
        if (g_ov !== 6'b011110) begin errors++; $display("FAIL eq_out_valid: got %b expected 011110", g_ov); end
        checks++;
        if (g_rs !== 6'b001010) begin errors++; $display("FAIL eq_result: got %b expected 001010", g_rs); end
        checks++;
        if (g_gt !== 6'b000100) begin errors++; $display("FAIL eq_greater: got %b expected 000100", g_gt); end
        checks++;
        if (g_lt !== 6'b010000) begin errors++; $display("FAIL eq_less: got %b expected 010000", g_lt); end
        checks++;
        if (g_eq !== 6'b001010) begin errors++; $display("FAIL eq_equal: got %b expected 001010", g_eq); end
        checks++;
        if (cnt0 !== 16'd2) begin errors++; $display("FAIL eq_match_cnt: got %0d expected 2", cnt0); end
    endtask

    task automatic test_signed();
        tick(1'b1, 8'hFF, 8'h01, 3'd2, 1'b0, 1'b0);
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        checks++;
        if ({ov[0], rs[0], lt[0], gt[0]} !== 4'b1001) begin
            errors++;
            $display("FAIL unsigned_lt {ov,res,lt,gt}: got %b expected 1001", {ov[0], rs[0], lt[0], gt[0]});
        end
        checks++;
        if ({ov[1], rs[1], lt[1], gt[1]} !== 4'b1110) begin
            errors++;
            $display("FAIL signed_lt {ov,res,lt,gt}: got %b expected 1110", {ov[1], rs[1], lt[1], gt[1]});
        end
    endtask

    task automatic test_run();
        logic [9:0] g_hit, g_ov, g_rs;
        logic [7:0] v8;
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            v8 = 8'($urandom_range(0, 255));
            if (k == 2 || k == 3 || k >= 8) tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
            else if (k == 7)                tick(1'b1, v8, v8 + 8'd1, 3'd0, 1'b0, 1'b0);
            else                            tick(1'b1, v8, v8, 3'd0, 1'b0, 1'b0);
            g_hit[k] = hit[0]; g_ov[k] = ov[0]; g_rs[k] = rs[0];
        end
        checks++;
        if (g_hit !== 10'b0011000000) begin errors++; $display("FAIL run_hit: got %b expected 0011000000", g_hit); end
        checks++;
        if (g_ov !== 10'b0111100110) begin errors++; $display("FAIL run_out_valid: got %b expected 0111100110", g_ov); end
        checks++;
        if (g_rs !== 10'b0011100110) begin errors++; $display("FAIL run_result: got %b expected 0011100110", g_rs); end
        checks++;
        if (cnt0 !== 16'd5) begin errors++; $display("FAIL run_match_cnt: got %0d expected 5", cnt0); end
    endtask

    task automatic test_saturation();
        logic [7:0] aa;
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            aa = 8'($urandom_range(0, 255));
            tick(k < 9, aa, 8'($urandom_range(0, int'(aa))), 3'd5, 1'b0, 1'b0);
            if (k >= 1) begin
                checks++;
                if (int'(cnt2) !== ((k < 7) ? k : 7)) begin
                    errors++;
                    $display("FAIL sat_cnt out%0d: got %0d expected %0d", k, cnt2, (k < 7) ? k : 7);
                end
                checks++;
                if (sat[2] !== (k >= 7)) begin
                    errors++;
                    $display("FAIL sat_flag out%0d: got %b expected %b", k, sat[2], (k >= 7));
                end
            end
        end
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0);
        checks++;
        if ({cnt2, sat[2]} !== 4'b0000) begin
            errors++;
            $display("FAIL sat_clear {cnt,sat}: got %b expected 0000", {cnt2, sat[2]});
        end
    endtask

    task automatic test_clear_collide();
        logic any_hit;
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) tick(1'b1, 8'(k * 3), 8'(k * 3), 3'd0, 1'b0, 1'b0);
        checks++;
        if (hit[0] !== 1'b1 || cnt0 !== 16'd4) begin
            errors++;
            $display("FAIL pre_clear hit/cnt: got %b/%0d expected 1/4", hit[0], cnt0);
        end
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0);
        checks++;
        if ({ov[0], rs[0]} !== 2'b11) begin
            errors++;
            $display("FAIL clear_collide ov/res: got %b expected 11", {ov[0], rs[0]});
        end
        checks++;
        if (cnt0 !== 16'd0 || hit[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_collide cnt/hit: got %0d/%b expected 0/0", cnt0, hit[0]);
        end
        idle(1);
        any_hit = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) tick(1'b1, 8'd42, 8'd42, 3'd0, 1'b0, 1'b0);
            else       tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
            any_hit = any_hit | hit[0];
        end
        checks++;
        if (any_hit !== 1'b0 || cnt0 !== 16'd3) begin
            errors++;
            $display("FAIL post_clear run hit/cnt: got %b/%0d expected 0/3", any_hit, cnt0);
        end
    endtask

    task automatic test_rst_flight();
        tick(1'b1, 8'd3, 8'd3, 3'd0, 1'b0, 1'b0);
        tick(1'b1, 8'd7, 8'd7, 3'd0, 1'b0, 1'b1);
        checks++;
        if ({ov[0], rs[0], eq[0], lt[0], gt[0], hit[0], sat[0]} !== 7'b0 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL rst_flight outputs: got %b cnt %0d expected 0000000 cnt 0",
                     {ov[0], rs[0], eq[0], lt[0], gt[0], hit[0], sat[0]}, cnt0);
        end
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL rst_flight drain: got ov %b expected 0", ov[0]); end
        tick(1'b1, 8'd9, 8'd9, 3'd0, 1'b0, 1'b0);
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL rst_next edge1: got ov %b expected 0", ov[0]); end
        tick(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        checks++;
        if ({ov[0], rs[0]} !== 2'b11 || cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL rst_next edge2 ov/res/cnt: got %b/%0d expected 11/1", {ov[0], rs[0]}, cnt0);
        end
    endtask

    task automatic test_random();
        logic [7:0]  aa;
        logic [15:0] ac;
        for (int t = 0; t < 400; t++) begin
            aa = 8'($urandom_range(0, 255));
            tick($urandom_range(0, 3) != 0, aa,
                 ($urandom_range(0, 2) == 0) ? aa : 8'($urandom_range(0, 255)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 30) == 0, $urandom_range(0, 60) == 0);
            for (int i = 0; i < 3; i++) begin
                ac = (i == 0) ? cnt0 : (i == 1) ? cnt1 : {13'd0, cnt2};
                checks++;
                if ({ov[i], rs[i], eq[i], lt[i], gt[i], hit[i], sat[i]} !==
                    {e_ov[i], e_rs[i], e_eq[i], e_lt[i], e_gt[i], e_hit[i], m_sat[i]}) begin
                    errors++;
                    $display("FAIL rand_flags inst%0d cyc%0d {ov,res,eq,lt,gt,hit,sat}: got %b expected %b", i, t,
                             {ov[i], rs[i], eq[i], lt[i], gt[i], hit[i], sat[i]},
                             {e_ov[i], e_rs[i], e_eq[i], e_lt[i], e_gt[i], e_hit[i], m_sat[i]});
                end
                checks++;
                if (ac !== 16'(m_cnt[i])) begin
                    errors++;
                    $display("FAIL rand_cnt inst%0d cyc%0d: got %0d expected %0d", i, t, ac, m_cnt[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_eq_sequence();
        test_signed();
        test_run();
        test_saturation();
        test_clear_collide();
        test_rst_flight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
